// File: rtl/frame_tx_1010.sv
// frame_tx_1010: serial frame transmitter.
// Each frame is the preamble 1,0,1,0, then the latched payload MSB-first, then an
// optional even-parity bit. All outputs are registered and follow the state,
// the bit counter and the latched payload, so start/din never reach x combinationally.
module frame_tx_1010 #(
    parameter int PAYLOAD_W = 8,
    parameter int PARITY_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] din,
    output logic                 x,
    output logic                 x_en,
    output logic                 busy,
    output logic                 done
);

    // The counter walks both the 4 preamble bits and the payload bits.
    localparam int CNT_MAX = (PAYLOAD_W > 4) ? PAYLOAD_W : 4;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 x_q, x_d;
    logic                 x_en_q, x_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // State, datapath and output registers; reset clears everything and aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            x_q     <= 1'b0;
            x_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            x_q     <= x_d;
            x_en_q  <= x_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, counter, payload shifting and the next registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        x_d     = 1'b0;
        x_en_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Only IDLE accepts start; the payload is frozen here for the whole frame.
                if (start) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    shift_d = din;
                    par_d   = 1'b0;
                end
            end

            PRE: begin
                // Even counter positions carry 1, odd ones 0: 1,0,1,0.
                x_d    = ~cnt_q[0];
                x_en_d = 1'b1;
                busy_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                // Send the MSB, shift left and fold the sent bit into the parity.
                x_d     = shift_q[PAYLOAD_W-1];
                x_en_d  = 1'b1;
                busy_d  = 1'b1;
                shift_d = {shift_q[PAYLOAD_W-2:0], 1'b0};
                par_d   = par_q ^ shift_q[PAYLOAD_W-1];
                if (cnt_q == DATA_LAST) begin
                    state_d = (PARITY_EN != 0) ? PAR : DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PAR: begin
                x_d     = par_q;
                x_en_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                // start seen here is dropped, which yields the 2-cycle gap between frames.
                done_d  = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = '0;
                par_d   = 1'b0;
            end
        endcase
    end

    assign x    = x_q;
    assign x_en = x_en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_frame_tx_1010.sv
// Testbench for frame_tx_1010: two instances (8-bit payload with parity, 4-bit
// payload without). Expected {x, x_en, busy, done} per cycle are queued when a
// start is driven and popped one per clock; an empty queue means all-zero outputs.
module tb_frame_tx_1010;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] din_a;
    logic [3:0] din_b;
    logic       x_a, x_en_a, busy_a, done_a;
    logic       x_b, x_en_b, busy_b, done_b;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    frame_tx_1010 #(.PAYLOAD_W(8), .PARITY_EN(1)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .din   (din_a),
        .x     (x_a),
        .x_en  (x_en_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    frame_tx_1010 #(.PAYLOAD_W(4), .PARITY_EN(0)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .din   (din_b),
        .x     (x_b),
        .x_en  (x_en_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    // One comparison of a {x, x_en, busy, done} vector.
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed x/x_en/busy/done=%b expected %b", tag, obs, exp);
        end
    endtask

    // Queue the expected cycles of one frame: acceptance cycle, frame bits, done.
    task automatic push_frame(input bit sel, input logic [15:0] d, input int w, input bit pe);
        logic [3:0] e[$];
        logic       p;
        p = 1'b0;
        e.push_back(4'b0000);
        for (int i = 0; i < 4; i++) e.push_back({((i % 2) == 0), 3'b110});
        for (int i = w - 1; i >= 0; i--) begin
            e.push_back({d[i], 3'b110});
            p ^= d[i];
        end
        if (pe) e.push_back({p, 3'b110});
        e.push_back(4'b0001);
        foreach (e[k]) begin
            if (sel) q_b.push_back(e[k]);
            else     q_a.push_back(e[k]);
        end
        $display("queued frame dut_%s din=%h width=%0d parity_en=%0d parity=%0d", sel ? "b" : "a", d, w, pe, p);
    endtask

    // Advance n clocks, comparing both instances #1 after each rising edge.
    task automatic run(input int n, input string tag);
        logic [3:0] ea, eb;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            ea = 4'b0000;
            eb = 4'b0000;
            if (q_a.size() > 0) ea = q_a.pop_front();
            if (q_b.size() > 0) eb = q_b.pop_front();
            check($sformatf("%s_a@%0d", tag, cyc), {x_a, x_en_a, busy_a, done_a}, ea);
            check($sformatf("%s_b@%0d", tag, cyc), {x_b, x_en_b, busy_b, done_b}, eb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        din_a   = 8'h00;
        din_b   = 4'h0;

        // Reset state
        run(3, "reset");
        rst = 1'b1;
        run(2, "idle");

        // 8'hA5 with parity: 1010_10100101_0
        start_a = 1'b1;
        din_a   = 8'hA5;
        push_frame(1'b0, 16'h00A5, 8, 1'b1);
        run(1, "a5");
        start_a = 1'b0;
        din_a   = 8'h00;
        run(17, "a5");

        // 8'h07 with parity: 1010_00000111_1
        start_a = 1'b1;
        din_a   = 8'h07;
        push_frame(1'b0, 16'h0007, 8, 1'b1);
        run(1, "h07");
        start_a = 1'b0;
        run(17, "h07");

        // 4-bit payload without parity: 1010_1100, then done
        start_b = 1'b1;
        din_b   = 4'hC;
        push_frame(1'b1, 16'h000C, 4, 1'b0);
        run(1, "b_c");
        start_b = 1'b0;
        din_b   = 4'h3;
        run(12, "b_c");

        // start and din=FF mid-frame are ignored
        start_a = 1'b1;
        din_a   = 8'h5A;
        push_frame(1'b0, 16'h005A, 8, 1'b1);
        run(1, "midstart");
        start_a = 1'b0;
        run(4, "midstart");
        start_a = 1'b1;
        din_a   = 8'hFF;
        run(1, "midstart");
        start_a = 1'b0;
        run(16, "midstart");

        // start held for 40 cycles: frames every 15 cycles (done + one idle between)
        start_a = 1'b1;
        din_a   = 8'h96;
        push_frame(1'b0, 16'h0096, 8, 1'b1);
        push_frame(1'b0, 16'h0096, 8, 1'b1);
        push_frame(1'b0, 16'h0096, 8, 1'b1);
        run(40, "held");
        start_a = 1'b0;
        run(10, "held");

        // Reset mid-frame: outputs drop at once, no done, no resumption
        start_a = 1'b1;
        din_a   = 8'hC3;
        push_frame(1'b0, 16'h00C3, 8, 1'b1);
        run(1, "abort");
        start_a = 1'b0;
        run(6, "abort");
        rst = 1'b0;
        #1;
        check("rst_async_a", {x_a, x_en_a, busy_a, done_a}, 4'b0000);
        q_a.delete();
        q_b.delete();
        run(3, "rst_hold");
        rst     = 1'b1;
        start_a = 1'b1;
        din_a   = 8'h3C;
        push_frame(1'b0, 16'h003C, 8, 1'b1);
        run(1, "fresh");
        start_a = 1'b0;
        run(18, "fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
